pf_ccc_lock_ctrl: RTL and testbench
===================================

# pf_ccc_lock_ctrl

Lock supervisor and reset sequencer for the PolarFire CCC/PLL that generates the fabric clock. Runs on the free-running reference clock that also feeds the CCC. Holds the PLL in power-down at start-up and filters its lock indication. Releases staged fabric resets only after lock is stable, re-asserts them on loss of lock, and power-cycles the PLL if lock is not achieved within a timeout.

## Interface
Parameters:
- PD_CYCLES, 16: cycles PLL_POWERDOWN_N is held low per power-down.
- LOCK_STABLE, 64: consecutive synchronized-lock cycles required before reset release.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a PLL restart.
- STAGE_GAP, 8: cycles between successive reset-stage releases (≥1).
- N_RST, 3: number of staged reset outputs (≥1).

Ports:
- CLK  in  1  free-running reference clock, same source as the CCC REF_CLK.
- RESET  in  1  **one clock; reset is synchronous and active-high**.
- PLL_LOCK  in  1  CCC lock output, asynchronous to CLK.
- CLR_STATUS  in  1  single-cycle clear of status counters and flag.
- PLL_POWERDOWN_N  out  1  CCC power-down, active-low.
- SYS_RESET  out  N_RST  staged fabric resets, active-high; bit 0 is released first.
- READY  out  1  all stages released, PLL locked.
- LOCK_LOSS_CNT  out  8  saturating count of lock losses after release began.
- RETRY_CNT  out  4  saturating count of timeout-driven PLL restarts.
- TIMEOUT_ERR  out  1  sticky; set by the first timeout.

## Operation
- PLL_LOCK passes through a 2-FF synchronizer (lock_s) before any use.
- FSM states: PWRDN, WAIT_LOCK, RELEASE, RUN.
- PWRDN: PLL_POWERDOWN_N=0 for PD_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK:
  - stable_cnt increments while lock_s=1 and clears when lock_s=0.
  - When lock_s=1 and stable_cnt==LOCK_STABLE-1, go to RELEASE.
  - timeout_cnt clears on entry and increments each cycle. When it reaches LOCK_TIMEOUT-1, go to PWRDN, set TIMEOUT_ERR, and increment RETRY_CNT.
  - If the stable and timeout conditions occur in the same cycle, RELEASE wins.
- RELEASE:
  - SYS_RESET[0] deasserts on the first RELEASE cycle.
  - SYS_RESET[i] deasserts STAGE_GAP cycles after SYS_RESET[i-1].
  - The state becomes RUN, with READY=1, in the same cycle SYS_RESET[N_RST-1] deasserts.
- Lock loss: lock_s=0 while in RELEASE or RUN causes, on the next cycle:
  - all SYS_RESET=1 and READY=0;
  - state WAIT_LOCK with stable_cnt and timeout_cnt cleared;
  - LOCK_LOSS_CNT+1.
  - No power-down is issued.
- Status counters saturate at all-ones.
- CLR_STATUS zeroes LOCK_LOSS_CNT, RETRY_CNT and TIMEOUT_ERR on the next cycle. If an increment or set coincides with the clear, the result is 1 (the event is kept).

## Timing
- All outputs are registered.
- Reset values: state=PWRDN, PLL_POWERDOWN_N=0, SYS_RESET=all ones, READY=0, LOCK_LOSS_CNT=0, RETRY_CNT=0, TIMEOUT_ERR=0. The synchronizer flops are cleared.
- RESET asserted mid-operation returns every output and counter to its reset value at the next edge, and restarts a full PWRDN.
- PLL_LOCK to lock_s latency: 2 cycles. lock_s to SYS_RESET assertion on loss: 1 cycle. Worst-case loss detection: 3 cycles.
- Minimum cycles from RESET deassertion to READY, with lock already high: PD_CYCLES + LOCK_STABLE + (N_RST-1)·STAGE_GAP.
- Counter widths are $clog2(param+1). Counters must not wrap.

## Structure
- Package pf_ccc_ctrl_pkg:
  - state enum (PWRDN, WAIT_LOCK, RELEASE, RUN);
  - LOSS_CNT_W=8 and RETRY_CNT_W=4;
  - counter-width helper function.
- Sub-module pf_ccc_lock_sync: generic 2-FF synchronizer with synchronous active-high clear.
- The FSM, counters and stage shifter stay in the top module.

## Test plan
All scenarios use PD_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, STAGE_GAP=2, N_RST=3, with RESET deasserted at cycle 0.
- Clean start, PLL_LOCK=1 throughout:
  - PLL_POWERDOWN_N rises at cycle 4.
  - SYS_RESET becomes 3'b110 at cycle 12, 3'b100 at cycle 14 and 3'b000 at cycle 16.
  - READY=1 at cycle 16.
- Lock glitch: PLL_LOCK low for 1 cycle at cycle 8 → stable_cnt restarts and READY is delayed; no lock-loss count.
- Lock loss in RUN: PLL_LOCK low at cycle 30 → SYS_RESET=3'b111 and READY=0 at cycle 33; LOCK_LOSS_CNT=1; READY returns after re-stabilization.
- No lock, PLL_LOCK=0 throughout:
  - PLL_POWERDOWN_N low again at cycle 68; TIMEOUT_ERR=1 and RETRY_CNT=1.
  - After 15 further timeouts, RETRY_CNT saturates at 15.
- CLR_STATUS coincident with a lock-loss increment → LOCK_LOSS_CNT=1 the next cycle. CLR_STATUS alone → all status outputs 0.
- RESET pulsed while in RELEASE → all outputs return to reset values at the next cycle, and the full sequence repeats from PWRDN.

Source files
------------

// File: rtl/pf_ccc_ctrl_pkg.sv
// rtl/pf_ccc_ctrl_pkg.sv - shared types and widths for the CCC lock supervisor
package pf_ccc_ctrl_pkg;

  typedef enum logic [1:0] {
    PWRDN     = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  // Bits needed to hold 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pf_ccc_lock_sync.sv
// rtl/pf_ccc_lock_sync.sv - 2-FF synchronizer with synchronous active-high clear
module pf_ccc_lock_sync (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pf_ccc_lock_ctrl.sv
// rtl/pf_ccc_lock_ctrl.sv - PLL lock supervisor and staged fabric reset sequencer
module pf_ccc_lock_ctrl
  import pf_ccc_ctrl_pkg::*;
#(
  parameter int PD_CYCLES    = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGE_GAP    = 8,
  parameter int N_RST        = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PLL_LOCK,
  input  logic                   CLR_STATUS,
  output logic                   PLL_POWERDOWN_N,
  output logic [N_RST-1:0]       SYS_RESET,
  output logic                   READY,
  output logic [LOSS_CNT_W-1:0]  LOCK_LOSS_CNT,
  output logic [RETRY_CNT_W-1:0] RETRY_CNT,
  output logic                   TIMEOUT_ERR
);

  localparam int PD_W  = cnt_w(PD_CYCLES);
  localparam int ST_W  = cnt_w(LOCK_STABLE);
  localparam int TO_W  = cnt_w(LOCK_TIMEOUT);
  localparam int GAP_W = cnt_w(STAGE_GAP);

  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

  state_t                 r_state;
  logic                   r_pwrdn_n;
  logic [N_RST-1:0]       r_sys_reset;
  logic                   r_ready;
  logic [PD_W-1:0]        r_pd_cnt;
  logic [ST_W-1:0]        r_stable_cnt;
  logic [TO_W-1:0]        r_timeout_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [LOSS_CNT_W-1:0]  r_loss_cnt;
  logic [RETRY_CNT_W-1:0] r_retry_cnt;
  logic                   r_timeout_err;

  logic             w_lock_s;
  logic             w_stable_hit;
  logic             w_timeout_hit;
  logic             w_loss_evt;
  logic             w_retry_evt;
  logic [N_RST-1:0] w_sys_next;

  pf_ccc_lock_sync u_lock_sync (
    .i_clk (CLK),
    .i_clr (RESET),
    .i_d   (PLL_LOCK),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_stable_hit  = w_lock_s && (r_stable_cnt == ST_LAST);
    w_timeout_hit = (r_timeout_cnt == TO_LAST);
    w_loss_evt    = !w_lock_s && ((r_state == RELEASE) || (r_state == RUN));
    w_retry_evt   = (r_state == WAIT_LOCK) && w_timeout_hit && !w_stable_hit;
    // Stages release low bit first; the shift empties the vector on the last stage.
    w_sys_next    = r_sys_reset << 1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= PWRDN;
      r_pwrdn_n     <= 1'b0;
      r_sys_reset   <= '1;
      r_ready       <= 1'b0;
      r_pd_cnt      <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_gap_cnt     <= '0;
    end else if (w_loss_evt) begin
      // Lock loss re-holds the fabric but leaves the PLL powered.
      r_state       <= WAIT_LOCK;
      r_sys_reset   <= '1;
      r_ready       <= 1'b0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_gap_cnt     <= '0;
    end else begin
      case (r_state)
        PWRDN: begin
          if (r_pd_cnt == PD_LAST) begin
            r_state       <= WAIT_LOCK;
            r_pwrdn_n     <= 1'b1;
            r_pd_cnt      <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
          end else begin
            r_pd_cnt <= r_pd_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (w_stable_hit) begin
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_gap_cnt     <= '0;
            r_sys_reset   <= w_sys_next;
            if (w_sys_next == '0) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= RELEASE;
            end
          end else if (w_timeout_hit) begin
            r_state       <= PWRDN;
            r_pwrdn_n     <= 1'b0;
            r_pd_cnt      <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
            r_stable_cnt  <= w_lock_s ? r_stable_cnt + 1'b1 : '0;
          end
        end
        RELEASE: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt   <= '0;
            r_sys_reset <= w_sys_next;
            if (w_sys_next == '0) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= PWRDN;
        end
      endcase
    end
  end

  // A clear that lands with an event keeps the event as a count of one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_loss_cnt    <= '0;
      r_retry_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (CLR_STATUS) begin
        r_loss_cnt <= w_loss_evt ? LOSS_CNT_W'(1) : '0;
      end else if (w_loss_evt && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end

      if (CLR_STATUS) begin
        r_retry_cnt <= w_retry_evt ? RETRY_CNT_W'(1) : '0;
      end else if (w_retry_evt && (r_retry_cnt != '1)) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end

      if (w_retry_evt) begin
        r_timeout_err <= 1'b1;
      end else if (CLR_STATUS) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign PLL_POWERDOWN_N = r_pwrdn_n;
  assign SYS_RESET       = r_sys_reset;
  assign READY           = r_ready;
  assign LOCK_LOSS_CNT   = r_loss_cnt;
  assign RETRY_CNT       = r_retry_cnt;
  assign TIMEOUT_ERR     = r_timeout_err;

endmodule

// File: tb/tb_pf_ccc_lock_ctrl.sv
// tb/tb_pf_ccc_lock_ctrl.sv - directed and random bench for pf_ccc_lock_ctrl
module tb_pf_ccc_lock_ctrl;

  localparam int PD  = 4;
  localparam int LS  = 8;
  localparam int LT  = 64;
  localparam int GAP = 2;
  localparam int N   = 3;

  localparam int M_PD   = 0;
  localparam int M_WAIT = 1;
  localparam int M_REL  = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         PLL_LOCK = 1'b0;
  logic         CLR_STATUS = 1'b0;
  logic         PLL_POWERDOWN_N;
  logic [N-1:0] SYS_RESET;
  logic         READY;
  logic [7:0]   LOCK_LOSS_CNT;
  logic [3:0]   RETRY_CNT;
  logic         TIMEOUT_ERR;

  int errors = 0;
  int checks = 0;

  // Reference model: mode plus entry cycle; outputs derived from elapsed time.
  int n;
  int mode;
  int e;
  int streak;
  int m_loss;
  int m_retry;
  int m_terr;
  bit hist[$];

  pf_ccc_lock_ctrl #(
    .PD_CYCLES    (PD),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .STAGE_GAP    (GAP),
    .N_RST        (N)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PLL_LOCK        (PLL_LOCK),
    .CLR_STATUS      (CLR_STATUS),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .SYS_RESET       (SYS_RESET),
    .READY           (READY),
    .LOCK_LOSS_CNT   (LOCK_LOSS_CNT),
    .RETRY_CNT       (RETRY_CNT),
    .TIMEOUT_ERR     (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int rel;
    int exp_sys;
    int exp_rdy;
    exp_sys = (1 << N) - 1;
    exp_rdy = 0;
    if (mode == M_REL) begin
      rel = (n - e) / GAP + 1;
      if (rel > N) rel = N;
      exp_sys = ((1 << N) - 1) & ~((1 << rel) - 1);
      exp_rdy = (rel == N) ? 1 : 0;
    end
    chk("m_pwrdn_n", {31'd0, PLL_POWERDOWN_N}, (mode != M_PD) ? 1 : 0);
    chk("m_sys_reset", {29'd0, SYS_RESET}, exp_sys);
    chk("m_ready", {31'd0, READY}, exp_rdy);
    chk("m_loss_cnt", {24'd0, LOCK_LOSS_CNT}, m_loss);
    chk("m_retry_cnt", {28'd0, RETRY_CNT}, m_retry);
    chk("m_timeout_err", {31'd0, TIMEOUT_ERR}, m_terr);
  endtask

  task automatic do_reset(input int edges, input logic lock);
    RESET = 1'b1;
    PLL_LOCK = lock;
    CLR_STATUS = 1'b0;
    repeat (edges) @(posedge CLK);
    #1;
    RESET = 1'b0;
    n = 0; mode = M_PD; e = 0; streak = 0;
    m_loss = 0; m_retry = 0; m_terr = 0;
    hist.delete();
    chk("rst_pwrdn_n", {31'd0, PLL_POWERDOWN_N}, 0);
    chk("rst_sys_reset", {29'd0, SYS_RESET}, 32'h7);
    chk("rst_ready", {31'd0, READY}, 0);
    chk("rst_loss", {24'd0, LOCK_LOSS_CNT}, 0);
    chk("rst_retry", {28'd0, RETRY_CNT}, 0);
    chk("rst_terr", {31'd0, TIMEOUT_ERR}, 0);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic tick(input logic lock, input logic clr);
    bit ls;
    bit loss_ev;
    bit retry_ev;
    PLL_LOCK = lock;
    CLR_STATUS = clr;
    hist.push_back(lock);
    ls = (n >= 2) ? hist[n - 2] : 1'b0;
    loss_ev = 1'b0;
    retry_ev = 1'b0;
    case (mode)
      M_PD: if (n - e == PD - 1) begin mode = M_WAIT; e = n + 1; streak = 0; end
      M_WAIT: begin
        streak = ls ? streak + 1 : 0;
        if (streak == LS) begin
          mode = M_REL; e = n + 1;
        end else if (n - e == LT - 1) begin
          mode = M_PD; e = n + 1; retry_ev = 1'b1;
        end
      end
      default: if (!ls) begin mode = M_WAIT; e = n + 1; streak = 0; loss_ev = 1'b1; end
    endcase
    if (clr) m_loss = loss_ev ? 1 : 0;
    else if (loss_ev && m_loss < 255) m_loss++;
    if (clr) m_retry = retry_ev ? 1 : 0;
    else if (retry_ev && m_retry < 15) m_retry++;
    if (retry_ev) m_terr = 1;
    else if (clr) m_terr = 0;
    @(posedge CLK);
    #1;
    n++;
    check_model();
  endtask

  initial begin
    // Clean start followed by a lock loss in RUN
    do_reset(2, 1'b1);
    for (int c = 0; c < 50; c++) begin
      tick((c == 30 || c == 31) ? 1'b0 : 1'b1, 1'b0);
      if (n == 3)  chk("pd_low_c3", {31'd0, PLL_POWERDOWN_N}, 0);
      if (n == 4)  chk("pd_high_c4", {31'd0, PLL_POWERDOWN_N}, 1);
      if (n == 11) chk("sys_c11", {29'd0, SYS_RESET}, 32'h7);
      if (n == 12) chk("sys_c12", {29'd0, SYS_RESET}, 32'h6);
      if (n == 14) chk("sys_c14", {29'd0, SYS_RESET}, 32'h4);
      if (n == 15) chk("ready_c15", {31'd0, READY}, 0);
      if (n == 16) chk("sys_c16", {29'd0, SYS_RESET}, 32'h0);
      if (n == 16) chk("ready_c16", {31'd0, READY}, 1);
      if (n == 32) chk("ready_c32", {31'd0, READY}, 1);
      if (n == 33) chk("loss_sys_c33", {29'd0, SYS_RESET}, 32'h7);
      if (n == 33) chk("loss_ready_c33", {31'd0, READY}, 0);
      if (n == 33) chk("loss_cnt_c33", {24'd0, LOCK_LOSS_CNT}, 1);
      if (n == 45) chk("relock_ready_c45", {31'd0, READY}, 0);
      if (n == 46) chk("relock_ready_c46", {31'd0, READY}, 1);
    end

    // One-cycle lock glitch while waiting for lock
    do_reset(2, 1'b1);
    for (int c = 0; c < 30; c++) begin
      tick((c == 8) ? 1'b0 : 1'b1, 1'b0);
      if (n == 12) chk("glitch_sys_c12", {29'd0, SYS_RESET}, 32'h7);
      if (n == 22) chk("glitch_ready_c22", {31'd0, READY}, 0);
      if (n == 23) chk("glitch_ready_c23", {31'd0, READY}, 1);
      if (n == 23) chk("glitch_loss_c23", {24'd0, LOCK_LOSS_CNT}, 0);
    end

    // Random lock segments with occasional status clears
    do_reset(1, 1'b0);
    while (n < 600) begin
      logic lvl;
      int len;
      lvl = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) tick(lvl, ($urandom_range(0, 15) == 0));
    end

    // No lock: periodic restarts until the retry counter saturates
    do_reset(1, 1'b0);
    for (int c = 0; c < 17 * 68; c++) begin
      tick(1'b0, 1'b0);
      if (n == 67)   chk("nolock_pd_c67", {31'd0, PLL_POWERDOWN_N}, 1);
      if (n == 68)   chk("nolock_pd_c68", {31'd0, PLL_POWERDOWN_N}, 0);
      if (n == 68)   chk("nolock_terr_c68", {31'd0, TIMEOUT_ERR}, 1);
      if (n == 68)   chk("nolock_retry_c68", {28'd0, RETRY_CNT}, 1);
      if (n == 1019) chk("retry_c1019", {28'd0, RETRY_CNT}, 14);
      if (n == 1088) chk("retry_sat_c1088", {28'd0, RETRY_CNT}, 15);
    end

    // Recover, take two losses, then a loss coincident with a clear
    for (int c = 0; c < 100; c++) tick(1'b1, 1'b0);
    chk("recover_ready", {31'd0, READY}, 1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) tick(1'b0, 1'b0);
      for (int c = 0; c < 30; c++) tick(1'b1, 1'b0);
    end
    chk("loss_two", {24'd0, LOCK_LOSS_CNT}, 2);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("clr_coinc_loss", {24'd0, LOCK_LOSS_CNT}, 1);
    chk("clr_coinc_retry", {28'd0, RETRY_CNT}, 0);
    chk("clr_coinc_terr", {31'd0, TIMEOUT_ERR}, 0);
    for (int c = 0; c < 30; c++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("clr_alone_loss", {24'd0, LOCK_LOSS_CNT}, 0);
    chk("clr_alone_retry", {28'd0, RETRY_CNT}, 0);
    chk("clr_alone_terr", {31'd0, TIMEOUT_ERR}, 0);

    // RESET pulsed during RELEASE restarts the full sequence
    do_reset(1, 1'b1);
    for (int c = 0; c < 13; c++) tick(1'b1, 1'b0);
    chk("pre_rst_sys_c13", {29'd0, SYS_RESET}, 32'h6);
    do_reset(1, 1'b1);
    for (int c = 0; c < 18; c++) begin
      tick(1'b1, 1'b0);
      if (n == 4)  chk("rerun_pd_c4", {31'd0, PLL_POWERDOWN_N}, 1);
      if (n == 12) chk("rerun_sys_c12", {29'd0, SYS_RESET}, 32'h6);
      if (n == 16) chk("rerun_ready_c16", {31'd0, READY}, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
